// File: rtl/rvj1_sram_bank_arb.sv
// Banked SRAM arbiter between the jedro_1 core port and the Caravel Wishbone slave.
// Define RVJ1_SRAM_ARB_RR_EN for per-bank round-robin conflict arbitration; otherwise the core always wins.

module rvj1_sram_bank_arb_lane #(
    parameter int BANK_AW = 9
) (
`ifdef RVJ1_SRAM_ARB_RR_EN
    input  logic               clk_i,
    input  logic               rstn_i,
`endif
    input  logic               a_hit,
    input  logic               a_we,
    input  logic [3:0]         a_be,
    input  logic [BANK_AW-1:0] a_addr,
    input  logic [31:0]        a_wdata,
    input  logic               w_hit,
    input  logic               w_we,
    input  logic [3:0]         w_sel,
    input  logic [BANK_AW-1:0] w_addr,
    input  logic [31:0]        w_wdata,
    output logic               a_win,
    output logic               w_win,
    output logic               csb,
    output logic               web,
    output logic [3:0]         wmask,
    output logic [BANK_AW-1:0] addr,
    output logic [31:0]        din
);
    logic conflict;
    assign conflict = a_hit & w_hit;

`ifdef RVJ1_SRAM_ARB_RR_EN
    // ptr_q: 0 names the core, 1 names Wishbone; only moves on a conflict
    logic ptr_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)       ptr_q <= 1'b0;
        else if (conflict) ptr_q <= ~ptr_q;
    end
    assign a_win = a_hit & ~(conflict &  ptr_q);
    assign w_win = w_hit & ~(conflict & ~ptr_q);
`else
    assign a_win = a_hit;
    assign w_win = w_hit & ~a_hit;
`endif

    always_comb begin
        csb   = 1'b1;
        web   = 1'b1;
        wmask = '0;
        addr  = '0;
        din   = '0;
        if (a_win) begin
            csb   = 1'b0;
            web   = ~a_we;
            wmask = a_be;
            addr  = a_addr;
            din   = a_wdata;
        end else if (w_win) begin
            csb   = 1'b0;
            web   = ~w_we;
            wmask = w_sel;
            addr  = w_addr;
            din   = w_wdata;
        end
    end
endmodule

module rvj1_sram_bank_arb #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_AW   = 9
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         a_req_i,
    input  logic                         a_we_i,
    input  logic [3:0]                   a_be_i,
    input  logic [BANK_AW+$clog2(NUM_BANKS)-1:0] a_addr_i,
    input  logic [31:0]                  a_wdata_i,
    output logic                         a_gnt_o,
    output logic                         a_rvalid_o,
    output logic [31:0]                  a_rdata_o,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [31:0]                  wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    output logic [NUM_BANKS-1:0]         sram_csb_o,
    output logic [NUM_BANKS-1:0]         sram_web_o,
    output logic [4*NUM_BANKS-1:0]       sram_wmask_o,
    output logic [BANK_AW*NUM_BANKS-1:0] sram_addr_o,
    output logic [32*NUM_BANKS-1:0]      sram_din_o,
    input  logic [32*NUM_BANKS-1:0]      sram_dout_i
);
    localparam int BANK_LG    = $clog2(NUM_BANKS);
    localparam int BANK_SEL_W = (BANK_LG > 0) ? BANK_LG : 1;
    localparam int ADDR_W     = BANK_AW + BANK_LG;

    typedef enum logic {WB_IDLE, WB_ACK} wb_state_e;
    wb_state_e wb_state_q, wb_state_d;

    logic [ADDR_W-1:0]     w_addr;
    logic [BANK_SEL_W-1:0] a_bank, w_bank, a_bank_q, w_bank_q;
    logic                  a_elig, w_elig, w_gnt, w_we_q;
    logic [1:0]            a_vld_pipe;

    logic [NUM_BANKS-1:0]              a_win_v, w_win_v;
    logic [NUM_BANKS-1:0][3:0]         wmask_v;
    logic [NUM_BANKS-1:0][BANK_AW-1:0] addr_v;
    logic [NUM_BANKS-1:0][31:0]        din_v, dout_v;

    // Wishbone byte-offset and high address bits alias away
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    assign w_addr = wbs_adr_i[ADDR_W+1:2];
    assign dout_v = sram_dout_i;

    if (NUM_BANKS == 1) begin : g_one_bank
        assign a_bank = '0;
        assign w_bank = '0;
    end else begin : g_multi_bank
        assign a_bank = a_addr_i[ADDR_W-1:BANK_AW];
        assign w_bank = w_addr[ADDR_W-1:BANK_AW];
    end

    // Gating with rstn_i keeps every strobe and grant quiet while reset is held
    assign a_elig = rstn_i & a_req_i;
    assign w_elig = rstn_i & wbs_stb_i & wbs_cyc_i & (wb_state_q == WB_IDLE);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rvj1_sram_bank_arb_lane #(.BANK_AW(BANK_AW)) u_lane (
`ifdef RVJ1_SRAM_ARB_RR_EN
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
`endif
            .a_hit   (a_elig && (a_bank == BANK_SEL_W'(b))),
            .a_we    (a_we_i),
            .a_be    (a_be_i),
            .a_addr  (a_addr_i[BANK_AW-1:0]),
            .a_wdata (a_wdata_i),
            .w_hit   (w_elig && (w_bank == BANK_SEL_W'(b))),
            .w_we    (wbs_we_i),
            .w_sel   (wbs_sel_i),
            .w_addr  (w_addr[BANK_AW-1:0]),
            .w_wdata (wbs_dat_i),
            .a_win   (a_win_v[b]),
            .w_win   (w_win_v[b]),
            .csb     (sram_csb_o[b]),
            .web     (sram_web_o[b]),
            .wmask   (wmask_v[b]),
            .addr    (addr_v[b]),
            .din     (din_v[b])
        );
    end

    assign sram_wmask_o = wmask_v;
    assign sram_addr_o  = addr_v;
    assign sram_din_o   = din_v;

    assign a_gnt_o       = |a_win_v;
    assign w_gnt         = |w_win_v;
    assign a_vld_pipe[0] = a_gnt_o & ~a_we_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            a_vld_pipe[1] <= 1'b0;
            a_bank_q      <= '0;
        end else begin
            a_vld_pipe[1] <= a_vld_pipe[0];
            if (a_gnt_o) a_bank_q <= a_bank;
        end
    end

    assign a_rvalid_o = a_vld_pipe[1];
    assign a_rdata_o  = a_vld_pipe[1] ? dout_v[a_bank_q] : 32'h0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_state_q <= WB_IDLE;
            w_bank_q   <= '0;
            w_we_q     <= 1'b0;
        end else begin
            wb_state_q <= wb_state_d;
            if (w_gnt) begin
                w_bank_q <= w_bank;
                w_we_q   <= wbs_we_i;
            end
        end
    end

    always_comb begin
        wb_state_d = wb_state_q;
        wbs_ack_o  = 1'b0;
        wbs_dat_o  = 32'h0;
        case (wb_state_q)
            WB_IDLE: if (w_gnt) wb_state_d = WB_ACK;
            WB_ACK: begin
                wbs_ack_o  = 1'b1;
                wb_state_d = WB_IDLE;
                if (!w_we_q) wbs_dat_o = dout_v[w_bank_q];
            end
            default: wb_state_d = WB_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rvj1_sram_bank_arb.sv
// Directed bench for rvj1_sram_bank_arb with two behavioural 512x32 SRAM banks.
// Honours RVJ1_SRAM_ARB_RR_EN for the conflict expectations.
`timescale 1ns/1ps
module tb_rvj1_sram_bank_arb;
    localparam int NB = 2;
    localparam int AW = 9;

    logic            clk = 1'b0;
    logic            rstn;
    logic            a_req, a_we;
    logic [3:0]      a_be;
    logic [AW:0]     a_addr;
    logic [31:0]     a_wdata;
    logic            a_gnt, a_rvalid;
    logic [31:0]     a_rdata;
    logic            stb, cyc, wwe;
    logic [3:0]      sel;
    logic [31:0]     adr, wdat;
    logic            ack;
    logic [31:0]     rdat;
    logic [NB-1:0]   csb, web;
    logic [4*NB-1:0] wmask;
    logic [AW*NB-1:0] saddr;
    logic [32*NB-1:0] din, dout;

    int n_chk = 0;
    int n_pass = 0;
    logic [3:0] exp_gnt, exp_ack;

    always #5 clk = ~clk;

    rvj1_sram_bank_arb #(.NUM_BANKS(NB), .BANK_AW(AW)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(wwe), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .sram_csb_o(csb), .sram_web_o(web), .sram_wmask_o(wmask),
        .sram_addr_o(saddr), .sram_din_o(din), .sram_dout_i(dout)
    );

    // Behavioural macros: sample at posedge, read data valid next cycle
    logic [31:0] mem [NB][512];
    for (genvar b = 0; b < NB; b++) begin : g_mem
        always @(posedge clk) begin
            if (!csb[b]) begin
                if (!web[b]) begin
                    for (int k = 0; k < 4; k++)
                        if (wmask[4*b+k]) mem[b][saddr[AW*b +: AW]][8*k +: 8] <= din[32*b+8*k +: 8];
                end else begin
                    dout[32*b +: 32] <= mem[b][saddr[AW*b +: AW]];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic core(input logic req, input logic we, input logic [3:0] be,
                        input logic [AW:0] ad, input logic [31:0] wd);
        a_req = req; a_we = we; a_be = be; a_addr = ad; a_wdata = wd;
    endtask

    task automatic wb(input logic s, input logic we, input logic [31:0] ad, input logic [31:0] wd);
        stb = s; cyc = s; wwe = we; sel = 4'hF; adr = ad; wdat = wd;
    endtask

    initial begin
        dout = '0;
        rstn = 1'b0;
        core(1'b1, 1'b0, 4'hF, 10'h005, 32'h0);
        wb(1'b0, 1'b0, 32'h0, 32'h0);
        tick(); tick(); #1;
        chk("rst_csb", 32'(csb), 32'h3);
        chk("rst_web", 32'(web), 32'h3);
        chk("rst_gnt", 32'(a_gnt), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_wbdat", rdat, 32'h0);

        // core writes
        tick(); rstn = 1'b1;
        core(1'b1, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF); #1;
        chk("wr_gnt", 32'(a_gnt), 32'h1);
        chk("wr_csb", 32'(csb), 32'h2);
        chk("wr_web", 32'(web), 32'h2);
        chk("wr_addr0", 32'(saddr[8:0]), 32'h5);
        chk("wr_din0", din[31:0], 32'hDEADBEEF);
        tick(); core(1'b1, 1'b1, 4'hF, 10'h006, 32'h12345678); #1;
        chk("wr_norvalid", 32'(a_rvalid), 32'h0);

        // back-to-back reads
        tick(); core(1'b1, 1'b0, 4'hF, 10'h005, 32'h0); #1;
        chk("rd0_gnt", 32'(a_gnt), 32'h1);
        tick(); core(1'b1, 1'b0, 4'hF, 10'h006, 32'h0); #1;
        chk("rd0_rvalid", 32'(a_rvalid), 32'h1);
        chk("rd0_rdata", a_rdata, 32'hDEADBEEF);
        tick(); core(1'b0, 1'b0, 4'hF, 10'h000, 32'h0); #1;
        chk("rd1_rvalid", 32'(a_rvalid), 32'h1);
        chk("rd1_rdata", a_rdata, 32'h12345678);
        tick(); #1;
        chk("rd_idle_rvalid", 32'(a_rvalid), 32'h0);
        chk("rd_idle_rdata", a_rdata, 32'h0);

        // Wishbone write then read of bank1 word 0
        wb(1'b1, 1'b1, 32'h0000_0800, 32'hCAFEF00D); #1;
        chk("wbw_noack", 32'(ack), 32'h0);
        chk("wbw_csb", 32'(csb), 32'h1);
        chk("wbw_addr1", 32'(saddr[17:9]), 32'h0);
        chk("wbw_din1", din[63:32], 32'hCAFEF00D);
        tick(); #1;
        chk("wbw_ack", 32'(ack), 32'h1);
        chk("wbw_ack_csb", 32'(csb), 32'h3);
        wb(1'b0, 1'b0, 32'h0, 32'h0);
        tick(); #1;
        chk("wbw_ack_1cyc", 32'(ack), 32'h0);
        wb(1'b1, 1'b0, 32'h0000_0800, 32'h0); #1;
        chk("wbr_csb", 32'(csb), 32'h1);
        tick(); #1;
        chk("wbr_ack", 32'(ack), 32'h1);
        chk("wbr_dat", rdat, 32'hCAFEF00D);
        wb(1'b0, 1'b0, 32'h0, 32'h0);
        tick(); #1;
        chk("wbr_ack_1cyc", 32'(ack), 32'h0);
        chk("wbr_dat_idle", rdat, 32'h0);

        // parallel: core reads bank0, Wishbone writes bank1
        core(1'b1, 1'b0, 4'hF, 10'h005, 32'h0);
        wb(1'b1, 1'b1, 32'hF000_0806, 32'hA5A5A5A5); #1;
        chk("par_gnt", 32'(a_gnt), 32'h1);
        chk("par_csb", 32'(csb), 32'h0);
        chk("par_web", 32'(web), 32'h1);
        chk("par_addr1", 32'(saddr[17:9]), 32'h1);
        tick();
        core(1'b0, 1'b0, 4'hF, 10'h000, 32'h0); #1;
        chk("par_rdata", a_rdata, 32'hDEADBEEF);
        chk("par_ack", 32'(ack), 32'h1);
        wb(1'b0, 1'b0, 32'h0, 32'h0);

        // byte mask
        tick(); core(1'b1, 1'b1, 4'hF, 10'h007, 32'hFFFFFFFF);
        tick(); core(1'b1, 1'b1, 4'b0101, 10'h007, 32'h11223344); #1;
        chk("bm_wmask", 32'(wmask[3:0]), 32'h5);
        tick(); core(1'b1, 1'b0, 4'hF, 10'h007, 32'h0);
        tick(); core(1'b0, 1'b0, 4'hF, 10'h000, 32'h0); #1;
        chk("bm_rdata", a_rdata, 32'hFF22FF44);

        // four cycles of bank0 conflict
`ifdef RVJ1_SRAM_ARB_RR_EN
        exp_gnt = 4'b1101;
        exp_ack = 4'b0100;
`else
        exp_gnt = 4'b1111;
        exp_ack = 4'b0000;
`endif
        tick();
        core(1'b1, 1'b0, 4'hF, 10'h005, 32'h0);
        wb(1'b1, 1'b1, 32'h0000_0010, 32'h00000055);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("cf_gnt%0d", c), 32'(a_gnt), 32'(exp_gnt[c]));
            chk($sformatf("cf_ack%0d", c), 32'(ack), 32'(exp_ack[c]));
            tick();
        end
        core(1'b0, 1'b0, 4'hF, 10'h000, 32'h0);
        wb(1'b0, 1'b0, 32'h0, 32'h0);
        tick(); tick();

        // reset mid-read drops the pending rvalid
        core(1'b1, 1'b0, 4'hF, 10'h006, 32'h0);
        @(posedge clk); #1;
        rstn = 1'b0; #1;
        chk("mid_rst_rvalid", 32'(a_rvalid), 32'h0);
        chk("mid_rst_csb", 32'(csb), 32'h3);
        chk("mid_rst_rdata", a_rdata, 32'h0);
        tick(); rstn = 1'b1; core(1'b0, 1'b0, 4'hF, 10'h000, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
